// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed RAM with byte strobes.
// Independent write/read responders, saturating access counters, sticky error flag.
module axi_lite_slave_mem #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int MEM_DEPTH_WORDS    = 256,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [CNT_WIDTH-1:0]          WR_COUNT,
  output logic [CNT_WIDTH-1:0]          RD_COUNT,
  output logic                          ERR_STICKY
);

  localparam int AW    = C_S_AXI_ADDR_WIDTH;
  localparam int IW    = AW - 2;
  localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_e;
  typedef enum logic {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_e;

  logic [31:0] mem [MEM_DEPTH_WORDS];

  wr_state_e           wr_state_q, wr_state_d;
  logic                aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
  logic [AW-1:0]       awaddr_q, awaddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

  rd_state_e           rd_state_q, rd_state_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

  logic                err_q, err_d;

  logic          awready, wready, arready;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [AW-1:0] awaddr_eff;
  logic [31:0]   wdata_eff;
  logic [3:0]    wstrb_eff;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          wr_in_range, rd_in_range;
  logic          mem_we;
  logic [31:0]   mem_rd;

  // Ready outputs are forced low while reset is asserted so nothing handshakes then.
  assign aw_hs = S_AXI_AWVALID & awready;
  assign w_hs  = S_AXI_WVALID  & wready;
  assign b_hs  = bvalid_q & S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID & arready;
  assign r_hs  = rvalid_q & S_AXI_RREADY;

  // A beat arriving this cycle is used directly so the commit needs no extra cycle.
  assign awaddr_eff  = aw_cap_q ? awaddr_q : S_AXI_AWADDR;
  assign wdata_eff   = w_cap_q  ? wdata_q  : S_AXI_WDATA;
  assign wstrb_eff   = w_cap_q  ? wstrb_q  : S_AXI_WSTRB;
  assign wr_idx      = awaddr_eff[AW-1:2];
  assign rd_idx      = S_AXI_ARADDR[AW-1:2];
  assign wr_in_range = 32'(wr_idx) < 32'(MEM_DEPTH_WORDS);
  assign rd_in_range = 32'(rd_idx) < 32'(MEM_DEPTH_WORDS);
  assign mem_rd      = mem[rd_idx[IDX_W-1:0]];

  always_comb begin
    wr_state_d = wr_state_q;
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_cnt_d   = wr_cnt_q;
    awready    = 1'b0;
    wready     = 1'b0;
    mem_we     = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        awready = ARESETN & ~aw_cap_q;
        wready  = ARESETN & ~w_cap_q;
        if (aw_hs) begin
          aw_cap_d = 1'b1;
          awaddr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_cap_d = 1'b1;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
        end
        if ((aw_cap_q | aw_hs) && (w_cap_q | w_hs)) begin
          mem_we     = wr_in_range;
          bvalid_d   = 1'b1;
          bresp_d    = wr_in_range ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          aw_cap_d   = 1'b0;
          w_cap_d    = 1'b0;
          wr_cnt_d   = (wr_cnt_q == {CNT_WIDTH{1'b1}}) ? wr_cnt_q : wr_cnt_q + 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    rd_cnt_d   = rd_cnt_q;
    arready    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        arready = ARESETN;
        if (ar_hs) begin
          rvalid_d   = 1'b1;
          rdata_d    = rd_in_range ? mem_rd : 32'h0;
          rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          rd_cnt_d   = (rd_cnt_q == {CNT_WIDTH{1'b1}}) ? rd_cnt_q : rd_cnt_q + 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  assign err_d = err_q | (b_hs & (bresp_q == RESP_SLVERR)) | (r_hs & (rresp_q == RESP_SLVERR));

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state_q <= WR_IDLE;
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_cnt_q   <= '0;
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rd_cnt_q   <= rd_cnt_d;
      err_q      <= err_d;
    end
  end

  // RAM has no reset; a same-edge read above sees pre-write contents.
  always_ff @(posedge ACLK) begin
    if (ARESETN && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_eff[b]) mem[wr_idx[IDX_W-1:0]][8*b +: 8] <= wdata_eff[8*b +: 8];
      end
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign WR_COUNT      = wr_cnt_q;
  assign RD_COUNT      = rd_cnt_q;
  assign ERR_STICKY    = err_q;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_eff[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem; counters narrowed to 4 bits to reach saturation quickly.
module tb_axi_lite_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [11:0] AWADDR, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [3:0]  WR_COUNT, RD_COUNT;
  logic        ERR_STICKY;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_slave_mem #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(12), .MEM_DEPTH_WORDS(256), .CNT_WIDTH(4)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .WR_COUNT(WR_COUNT), .RD_COUNT(RD_COUNT), .ERR_STICKY(ERR_STICKY)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    ARADDR = a; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0; d = RDATA; r = RRESP; RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    tick(); tick();
    n_checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      n_fail++; $display("FAIL reset_handshake: got %b required 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    n_checks++;
    if ({BRESP, RRESP, RDATA, WR_COUNT, RD_COUNT, ERR_STICKY} !== 45'b0) begin
      n_fail++; $display("FAIL reset_state: bresp=%b rresp=%b rdata=%h wr=%0d rd=%0d err=%b required all 0",
                         BRESP, RRESP, RDATA, WR_COUNT, RD_COUNT, ERR_STICKY);
    end
    ARESETN = 1'b1;
    #1;
    n_checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_basic();
    AWADDR = 12'h010; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    n_checks++;
    if ({BVALID, BRESP} !== 3'b100) begin
      n_fail++; $display("FAIL basic_bvalid: got bvalid=%b bresp=%b required 1 00", BVALID, BRESP);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    ARADDR = 12'h010; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    n_checks++;
    if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL basic_read: got rvalid=%b rresp=%b rdata=%h required 1 00 deadbeef", RVALID, RRESP, RDATA);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    n_checks++;
    if ({WR_COUNT, RD_COUNT} !== {4'd1, 4'd1}) begin
      n_fail++; $display("FAIL basic_counts: got wr=%0d rd=%0d required 1 1", WR_COUNT, RD_COUNT);
    end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0]  r;
    WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    n_checks++;
    if ({WREADY, AWREADY, BVALID} !== 3'b010) begin
      n_fail++; $display("FAIL w_first_ready: got wready=%b awready=%b bvalid=%b required 0 1 0", WREADY, AWREADY, BVALID);
    end
    tick(); tick();
    n_checks++;
    if (BVALID !== 1'b0) begin
      n_fail++; $display("FAIL w_first_no_b: got bvalid=%b required 0", BVALID);
    end
    AWADDR = 12'h020; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    n_checks++;
    if ({BVALID, BRESP} !== 3'b100) begin
      n_fail++; $display("FAIL w_first_bvalid: got bvalid=%b bresp=%b required 1 00", BVALID, BRESP);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    do_write(12'h020, 32'hAABBCCDD, 4'b0101);
    do_read(12'h020, d, r);
    n_checks++;
    if ({d, r} !== {32'h11BB33DD, 2'b00}) begin
      n_fail++; $display("FAIL strobe_merge: got %h/%b required 11bb33dd/00", d, r);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(12'h000, 32'hCAFEF00D, 4'hF);
    AWADDR = 12'h400; WDATA = 32'h0BADBAD0; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    n_checks++;
    if ({BVALID, BRESP, ERR_STICKY} !== 4'b1100) begin
      n_fail++; $display("FAIL oor_bresp: got bvalid=%b bresp=%b err=%b required 1 10 0", BVALID, BRESP, ERR_STICKY);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    n_checks++;
    if (ERR_STICKY !== 1'b1) begin
      n_fail++; $display("FAIL oor_sticky: got %b required 1", ERR_STICKY);
    end
    do_read(12'h400, d, r);
    n_checks++;
    if ({d, r} !== {32'h0, 2'b10}) begin
      n_fail++; $display("FAIL oor_read: got %h/%b required 00000000/10", d, r);
    end
    do_read(12'h000, d, r);
    n_checks++;
    if ({d, r, ERR_STICKY} !== {32'hCAFEF00D, 2'b00, 1'b1}) begin
      n_fail++; $display("FAIL oor_word0: got %h/%b err=%b required cafef00d/00 1", d, r, ERR_STICKY);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] wr0, rd0;
    wr0 = 4'd5; rd0 = 4'd4;
    AWADDR = 12'h040; WDATA = 32'h12345678; WSTRB = 4'hF; ARADDR = 12'h010;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, WREADY, ARREADY, WR_COUNT, RD_COUNT} !==
          {1'b1, 2'b00, 1'b1, 2'b00, 32'hDEADBEEF, 3'b000, wr0, rd0}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: b=%b/%b r=%b/%b rdata=%h rdy=%b%b%b wr=%0d rd=%0d required 1/00 1/00 deadbeef 000 5 4",
                           i, BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, WREADY, ARREADY, WR_COUNT, RD_COUNT);
      end
      tick();
    end
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    n_checks++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY, WR_COUNT, RD_COUNT} !== {5'b00111, 4'd6, 4'd5}) begin
      n_fail++; $display("FAIL bp_release: got valid=%b%b rdy=%b%b%b wr=%0d rd=%0d required 00 111 6 5",
                         BVALID, RVALID, AWREADY, WREADY, ARREADY, WR_COUNT, RD_COUNT);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    logic [1:0]  r;
    do_write(12'h030, 32'h0, 4'hF);
    AWADDR = 12'h030; WDATA = 32'h55; WSTRB = 4'hF; ARADDR = 12'h030;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    n_checks++;
    if ({RVALID, RDATA, BVALID} !== {1'b1, 32'h0, 1'b1}) begin
      n_fail++; $display("FAIL concurrent_old: got rvalid=%b rdata=%h bvalid=%b required 1 00000000 1", RVALID, RDATA, BVALID);
    end
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    do_read(12'h030, d, r);
    n_checks++;
    if ({d, r} !== {32'h55, 2'b00}) begin
      n_fail++; $display("FAIL concurrent_new: got %h/%b required 00000055/00", d, r);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    logic [1:0]  r;
    for (int i = 0; i < 12; i++) begin
      do_write(12'h050, 32'(i), 4'hF);
      do_read(12'h050, d, r);
    end
    n_checks++;
    if ({WR_COUNT, RD_COUNT, d} !== {4'hF, 4'hF, 32'd11}) begin
      n_fail++; $display("FAIL saturation: got wr=%0d rd=%0d last=%h required 15 15 0000000b", WR_COUNT, RD_COUNT, d);
    end
  endtask

  task automatic test_reset_inflight();
    AWADDR = 12'h400; WDATA = 32'h1; WSTRB = 4'hF; ARADDR = 12'h010;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    n_checks++;
    if ({BVALID, RVALID, ERR_STICKY} !== 3'b111) begin
      n_fail++; $display("FAIL inflight_pre: got bvalid=%b rvalid=%b err=%b required 1 1 1", BVALID, RVALID, ERR_STICKY);
    end
    ARESETN = 1'b0;
    tick();
    n_checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, WR_COUNT, RD_COUNT, ERR_STICKY, RDATA} !== 46'b0) begin
      n_fail++; $display("FAIL inflight_reset: rdy=%b%b%b valid=%b%b wr=%0d rd=%0d err=%b rdata=%h required all 0",
                         AWREADY, WREADY, ARREADY, BVALID, RVALID, WR_COUNT, RD_COUNT, ERR_STICKY, RDATA);
    end
    ARESETN = 1'b1;
    #1;
    n_checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b11100) begin
      n_fail++; $display("FAIL inflight_release: got rdy=%b%b%b valid=%b%b required 111 00",
                         AWREADY, WREADY, ARREADY, BVALID, RVALID);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0; WDATA = '0; WSTRB = '0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    test_reset();
    test_basic();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_concurrent();
    test_saturation();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
